// File: rtl/ssd_scan_pkg.sv
// Shared definitions for the seven-segment scan block: BCD codes and
// active-low segment patterns ordered {a,b,c,d,e,f,g,dp}.
package ssd_scan_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] seg_t;

    localparam bcd_t BCD_ZERO = 4'd0;
    localparam bcd_t BCD_NULL = 4'd13;

    localparam seg_t SSD_DARK = 8'hFF;
    localparam seg_t SSD_DASH = 8'b1111_1101;

    localparam seg_t SEG_0 = 8'b0000_0011;
    localparam seg_t SEG_1 = 8'b1001_1111;
    localparam seg_t SEG_2 = 8'b0010_0101;
    localparam seg_t SEG_3 = 8'b0000_1101;
    localparam seg_t SEG_4 = 8'b1001_1001;
    localparam seg_t SEG_5 = 8'b0100_1001;
    localparam seg_t SEG_6 = 8'b0100_0001;
    localparam seg_t SEG_7 = 8'b0001_1111;
    localparam seg_t SEG_8 = 8'b0000_0001;
    localparam seg_t SEG_9 = 8'b0000_1001;

    localparam logic [3:0] CTL_OFF = 4'b1111;

    // A digit that may be hidden as a leading zero: a literal zero or an
    // already-empty position.
    function automatic logic is_lead_code(bcd_t d);
        return (d == BCD_ZERO) || (d == BCD_NULL);
    endfunction

endpackage

// File: rtl/ssd_scan_if.sv
// Digit-bank / display bundle of the scan block. The master side owns the
// digit registers and blank control; the slave side is the scanner that
// drives the board pins.
interface ssd_scan_if;
    import ssd_scan_pkg::*;

    bcd_t       dig0;       // rightmost position
    bcd_t       dig1;
    bcd_t       dig2;
    bcd_t       dig3;       // leftmost position
    logic       blank;
    logic [3:0] ssd_ctl;    // active-low digit enables
    seg_t       display;    // active-low segments
    logic       frame_tick;

    modport master (
        output dig0, dig1, dig2, dig3, blank,
        input  ssd_ctl, display, frame_tick
    );

    modport slave (
        input  dig0, dig1, dig2, dig3, blank,
        output ssd_ctl, display, frame_tick
    );

endinterface

// File: rtl/ssd_decode.sv
// Purely combinational BCD to active-low seven-segment decoder.
// Code 13 is the empty-digit marker and stays dark; the other non-decimal
// codes show a dash so a corrupted register is visible on the board.
module ssd_decode
    import ssd_scan_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    // Map one BCD code to its segment pattern.
    always_comb begin
        // NOTE: assign a default before the case so every path drives seg and no latch is inferred.
        seg = SSD_DASH;
        case (bcd)
            4'd0:     seg = SEG_0;
            4'd1:     seg = SEG_1;
            4'd2:     seg = SEG_2;
            4'd3:     seg = SEG_3;
            4'd4:     seg = SEG_4;
            4'd5:     seg = SEG_5;
            4'd6:     seg = SEG_6;
            4'd7:     seg = SEG_7;
            4'd8:     seg = SEG_8;
            4'd9:     seg = SEG_9;
            BCD_NULL: seg = SSD_DARK;
            default:  seg = SSD_DASH;
        endcase
    end

endmodule

// File: rtl/ssd_scan.sv
// Four-digit common-anode display scanner.
// Snapshots the digit bank once per frame into a shadow copy so a frame never
// shows a mix of old and new digits, then lights one position at a time for
// SCAN_DIV clocks. Outputs are registered, one cycle behind the position.
// Optional build macro: LEADING_ZERO_BLANK_EN hides leading zeros on
// positions 3..1 (position 0 always shows).
module ssd_scan
    import ssd_scan_pkg::*;
#(
    parameter int SCAN_DIV = 100000,   // clocks per lit digit, >= 2
    parameter int CNT_W    = 17        // 2**CNT_W >= SCAN_DIV
) (
    input  logic       clk,
    input  logic       rst,
    ssd_scan_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       pos;
    bcd_t             shadow [4];
    logic             tick;
    logic             frame_end;
    seg_t             seg_lit;
    logic             suppress;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (pos == 2'd3);

    // Prescaler and position counter; position moves only on tick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt <= '0;
            pos <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            pos <= pos + 2'd1;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Latch the live digits at the frame boundary and flag the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow bank is reset explicitly so the display comes up dark, not with stale digits.
            for (int i = 0; i < 4; i++) shadow[i] <= BCD_NULL;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.frame_tick <= frame_end;
            if (frame_end) begin
                shadow[0] <= bus.dig0;
                shadow[1] <= bus.dig1;
                shadow[2] <= bus.dig2;
                shadow[3] <= bus.dig3;
            end
        end
    end

    ssd_decode u_decode (
        .bcd (shadow[pos]),
        .seg (seg_lit)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lead_dark;

    // A position is a hidden leading zero only if everything left of it is too.
    always_comb begin
        lead_dark    = 4'b0000;
        lead_dark[3] = is_lead_code(shadow[3]);
        lead_dark[2] = lead_dark[3] && is_lead_code(shadow[2]);
        lead_dark[1] = lead_dark[2] && is_lead_code(shadow[1]);
        suppress     = lead_dark[pos];
    end
`else
    assign suppress = 1'b0;
`endif

    // Drive the pins from the current position and its shadow digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ssd_ctl <= CTL_OFF;
            bus.display <= SSD_DARK;
        end else if (bus.blank) begin
            bus.ssd_ctl <= CTL_OFF;
            bus.display <= SSD_DARK;
        end else begin
            bus.ssd_ctl <= ~(4'b0001 << pos);
            bus.display <= suppress ? SSD_DARK : seg_lit;
        end
    end

endmodule

// File: tb/tb_ssd_scan.sv
// Self-checking bench for ssd_scan with SCAN_DIV=4: directed steps for each
// scan scenario followed by randomized digits/blank/reset, every cycle
// compared against a frame-arithmetic reference model.
module tb_ssd_scan;

    localparam int D     = 4;
    localparam int FRAME = 4 * D;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] tb_dig [4];
    logic tb_blank;

    ssd_scan_if bus ();

    assign bus.dig0  = tb_dig[0];
    assign bus.dig1  = tb_dig[1];
    assign bus.dig2  = tb_dig[2];
    assign bus.dig3  = tb_dig[3];
    assign bus.blank = tb_blank;

    ssd_scan #(.SCAN_DIV(D), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: t = clock edges since reset released, m_sh = digits
    // the display should currently be using.
    int         t;
    logic [3:0] m_sh [4];
    logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09,
                                 8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFD, 8'hFD};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [7:0] model_disp(input int p);
`ifdef LEADING_ZERO_BLANK_EN
        bit all_dark = 1'b1;
        for (int i = 3; i >= p; i--)
            if (!(m_sh[i] == 4'd0 || m_sh[i] == 4'd13)) all_dark = 1'b0;
        if (p != 0 && all_dark) return 8'hFF;
`endif
        return seg_tab[m_sh[p]];
    endfunction

    // One clock: predict, clock, compare, advance the model.
    task automatic cycle();
        logic [3:0] exp_ctl;
        logic [7:0] exp_disp;
        logic       exp_ft;
        logic       boundary;
        int         p;
        p        = (t / D) % 4;
        boundary = (t % FRAME) == FRAME - 1;
        if (rst) begin
            exp_ctl  = 4'hF;
            exp_disp = 8'hFF;
            exp_ft   = 1'b0;
        end else begin
            exp_ctl  = tb_blank ? 4'hF : ~(4'b0001 << p);
            exp_disp = tb_blank ? 8'hFF : model_disp(p);
            exp_ft   = boundary;
        end
        @(posedge clk);
        #1;
        check("model_ctl", {4'h0, bus.ssd_ctl}, {4'h0, exp_ctl});
        check("model_disp", bus.display, exp_disp);
        check("model_ft", {7'd0, bus.frame_tick}, {7'd0, exp_ft});
        if (rst) begin
            t = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 4'd13;
        end else begin
            if (boundary)
                for (int i = 0; i < 4; i++) m_sh[i] = tb_dig[i];
            t++;
        end
    endtask

    task automatic set_digs(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
        tb_dig[3] = d3;
        tb_dig[2] = d2;
        tb_dig[1] = d1;
        tb_dig[0] = d0;
    endtask

    task automatic to_frame_start();
        int guard = 0;
        while ((t % FRAME) != 0 && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
    endtask

    logic [3:0] walk [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] f1seg [4] = '{8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101};
`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] lz_seg [4] = '{8'b0000_0011, 8'b1001_1001, 8'hFF, 8'hFF};
`else
    logic [7:0] lz_seg [4] = '{8'b0000_0011, 8'b1001_1001, 8'b0000_0011, 8'b0000_0011};
`endif

    initial begin
        t = 0;
        for (int i = 0; i < 4; i++) m_sh[i] = 4'd13;
        tb_blank = 1'b0;
        set_digs(4'd3, 4'd2, 4'd1, 4'd0);

        // Reset for two cycles.
        rst = 1'b1;
        cycle();
        cycle();
        check("reset_ctl", {4'h0, bus.ssd_ctl}, 8'h0F);
        check("reset_disp", bus.display, 8'hFF);
        rst = 1'b0;

        // First frame after reset is dark; tick lands on its last edge.
        for (int j = 0; j < FRAME; j++) begin
            cycle();
            check("first_frame_dark", bus.display, 8'hFF);
        end
        check("first_frame_tick", {7'd0, bus.frame_tick}, 8'd1);

        // Second frame walks the latched 3,2,1,0; dig0 changes mid-frame.
        for (int j = 0; j < FRAME; j++) begin
            if (j == 2 * D) tb_dig[0] = 4'd7;
            cycle();
            check("walk_ctl", {4'h0, bus.ssd_ctl}, {4'h0, walk[j / D]});
            check("walk_disp", bus.display, f1seg[j / D]);
        end

        // Next frame shows the new dig0; load NULL/dash for the frame after.
        for (int j = 0; j < FRAME; j++) begin
            if (j == D) set_digs(4'd3, 4'd2, 4'd11, 4'd13);
            cycle();
            if (j < D) check("late_dig0", bus.display, 8'b0001_1111);
        end

        // NULL is dark, 11 is a dash; then blank for ten cycles.
        for (int j = 0; j < FRAME + 4; j++) begin
            if (j == 2 * D) tb_blank = 1'b1;
            if (j == 2 * D + 10) tb_blank = 1'b0;
            cycle();
            if (j < D) check("null_dark", bus.display, 8'hFF);
            else if (j < 2 * D) check("dash", bus.display, 8'b1111_1101);
            else if (j < 2 * D + 10) begin
                check("blank_ctl", {4'h0, bus.ssd_ctl}, 8'h0F);
                check("blank_disp", bus.display, 8'hFF);
            end
        end
        check("blank_resume_ctl", {4'h0, bus.ssd_ctl}, {4'h0, walk[((t - 1) / D) % 4]});

        // Reset in the middle of position 2.
        to_frame_start();
        for (int j = 0; j < 2 * D + 1; j++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_ctl", {4'h0, bus.ssd_ctl}, 8'h0F);
        check("midrst_disp", bus.display, 8'hFF);
        for (int i = 0; i < 4; i++) check("midrst_shadow", {4'h0, dut.shadow[i]}, 8'd13);
        for (int j = 0; j < D; j++) begin
            cycle();
            check("midrst_restart", {4'h0, bus.ssd_ctl}, 8'h0E);
        end

        // Leading zeros: 0,0,4,0.
        set_digs(4'd0, 4'd0, 4'd4, 4'd0);
        to_frame_start();
        for (int j = 0; j < FRAME; j++) cycle();
        for (int j = 0; j < FRAME; j++) begin
            cycle();
            check("lead_zero", bus.display, lz_seg[j / D]);
        end

        // Randomized digits, blank and occasional reset against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    tb_dig[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
                else
                    tb_dig[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd13;
            end
            if ($urandom_range(0, 15) == 0) tb_blank = ~tb_blank;
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ssd_scan.md
Name: ssd_scan

Overview:
Display-side reader for the 4-digit BCD register bank written by the keypad number-entry logic. Latches dig0..dig3 once per frame into a shadow copy so updates never tear mid-frame. Time-multiplexes the shadow digits onto a 4-digit common-anode seven-segment display. Sits between the number/digit registers and the board SSD pins.

Parameters:
SCAN_DIV, 100000, clk cycles each digit stays lit (minimum 2; benches use 4)
CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
dig0  in  4  BCD digit, rightmost position
dig1  in  4  BCD digit
dig2  in  4  BCD digit
dig3  in  4  BCD digit, leftmost position
blank  in  1  force the whole display dark while high
ssd_ctl  out  4  digit enables, active-low, bit i = position i
display  out  8  segments {a,b,c,d,e,f,g,dp}, active-low
frame_tick  out  1  one-cycle pulse when a new shadow frame is latched

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Prescaler cnt counts 0..SCAN_DIV-1, then wraps to 0. The cycle with cnt==SCAN_DIV-1 is "tick".
- Position register pos (2 bits) advances 0->1->2->3->0 on tick only.
- Frame boundary is tick with pos==3. On that cycle:
  - shadow0..3 <= dig0..3.
  - frame_tick is registered high on the next cycle, for exactly one cycle.
- dig inputs are sampled only at the frame boundary. Changes at any other time have no visible effect until the next frame.
- Outputs are registered from (pos, shadow), one cycle behind pos.
  - ssd_ctl = 4'b1111 with bit pos cleared.
  - display = decode(shadow[pos]).
- When blank==1, the next-cycle outputs are ssd_ctl=4'b1111 and display=8'hFF. The counters keep running and shadow latching continues.
- Decode, active-low {a..g,dp}, dp always off:
  - 0=0000_0011, 1=1001_1111, 2=0010_0101, 3=0000_1101, 4=1001_1001
  - 5=0100_1001, 6=0100_0001, 7=0001_1111, 8=0000_0001, 9=0000_1001
  - 13 (BCD_NULL) = 1111_1111 (dark)
  - 10, 11, 12, 14, 15 = 1111_1101 (dash, g only)
- Reset, synchronous and taking priority over everything:
  - cnt=0, pos=0, shadow0..3=BCD_NULL, ssd_ctl=4'b1111, display=8'hFF, frame_tick=0.
  - The first latch of real digits occurs 4*SCAN_DIV cycles after rst deasserts.
- Reset asserted mid-frame aborts the frame. No partial shadow update; the state is as above on the next cycle.
- Simultaneous tick and blank: pos still advances; outputs are dark.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: the displayed value of digit i (i = 3, 2, 1) is forced dark when shadow_i is 0 or BCD_NULL and every higher position is also dark. dig0 is never suppressed, so 0000 shows as "   0".
- Undefined: all positions decode literally, so 0000 shows as "0000".
- Suppression is evaluated on shadow values only, never on the live dig inputs.

Decomposition:
- Shared global definitions file: BCD_ZERO (4'd0), BCD_NULL (4'd13), SSD_DARK (8'hFF), SSD_DASH (8'b1111_1101), and the ten digit segment codes.
- One sub-module: ssd_decode, a purely combinational 4-bit BCD to 8-bit segment decoder. It is instantiated once and fed shadow[pos].

Test Plan:
1. SCAN_DIV=4; rst for 2 cycles; dig=3,2,1,0 (dig3..dig0) -> during the first 16 cycles display=8'hFF every cycle. frame_tick pulses once at cycle 16. Next frame: ssd_ctl walks 1110,1101,1011,0111, each for 4 cycles, with display 0000_0011, 1001_1111, 0010_0101, 0000_1101.
2. Change dig0 from 0 to 7 mid-frame (pos=2) -> position 0 keeps showing 0000_0011 until the next frame_tick, then shows 0001_1111.
3. dig0=13, dig1=11 -> position 0 shows 8'hFF; position 1 shows 1111_1101.
4. blank=1 for 10 cycles -> ssd_ctl=1111 and display=8'hFF from the following cycle. After release, pos has continued its sequence (no restart).
5. Assert rst at pos=2 mid-frame -> the next cycle shows ssd_ctl=1111, display=FF, and shadow reads back BCD_NULL. The frame restarts from pos 0.
6. With LEADING_ZERO_BLANK_EN, dig=0,0,4,0 (dig3..dig0) -> positions 3 and 2 are dark; position 1 shows 1001_1001; position 0 shows 0000_0011. Without the macro, positions 3 and 2 show 0000_0011.
